// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LCD panel: parks a valid/ready/SOP pixel stream on
// raster (0,0) and drives registered RGB, HD, VD and DEN, filling on stream starvation.
module lcd_timing_gen #(
  parameter int                DATA_W   = 24,
  parameter int                H_ACTIVE = 800,
  parameter int                H_FP     = 40,
  parameter int                H_SYNC   = 128,
  parameter int                H_BP     = 88,
  parameter int                V_ACTIVE = 480,
  parameter int                V_FP     = 10,
  parameter int                V_SYNC   = 2,
  parameter int                V_BP     = 33,
  parameter logic [DATA_W-1:0] FILL_RGB = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sop,
  output logic              pix_ready,
  output logic [DATA_W-1:0] rgb_out,
  output logic              hd,
  output logic              vd,
  output logic              den,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  typedef enum logic [0:0] {ALIGN, RUN} state_t;

  state_t            state_p0, state_nxt;
  logic [HW-1:0]     h_cnt_p0;
  logic [VW-1:0]     v_cnt_p0;
  logic              at_origin, active, hsync_region, vsync_region;
  logic              ready_c, take, starve;
  logic [DATA_W-1:0] rgb_p1;
  logic              hd_p1, vd_p1, vld_p1, frame_start_p1, underflow_p1;

  assign at_origin    = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  assign active       = (h_cnt_p0 < H_ACT_END) && (v_cnt_p0 < V_ACT_END);
  assign hsync_region = (h_cnt_p0 >= H_SYNC_BEG) && (h_cnt_p0 < H_SYNC_END);
  assign vsync_region = (v_cnt_p0 >= V_SYNC_BEG) && (v_cnt_p0 < V_SYNC_END);

  // p0: raster counters and stream lock state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      state_p0 <= ALIGN;
    end else begin
      state_p0 <= state_nxt;
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
    end
  end

  // ALIGN drops non-SOP pixels and parks an SOP until the raster origin
  always_comb begin
    state_nxt = state_p0;
    ready_c   = 1'b0;
    take      = 1'b0;
    starve    = 1'b0;
    case (state_p0)
      ALIGN: begin
        ready_c = pix_valid & (~pix_sop | at_origin);
        if (pix_valid && pix_sop && at_origin) begin
          take      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ready_c = active & ~(pix_sop & ~at_origin);
        take    = pix_valid & ready_c;
        if (active && !pix_valid) begin
          starve    = 1'b1;
          state_nxt = ALIGN;
        end else if (pix_valid && pix_sop && !at_origin) begin
          state_nxt = ALIGN;
        end
      end
      default: state_nxt = ALIGN;
    endcase
  end

  // Nothing is accepted while the block is held in reset.
  assign pix_ready = reset_n & ready_c;

  // p1: registered panel outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_p1         <= '0;
      hd_p1          <= 1'b1;
      vd_p1          <= 1'b1;
      vld_p1         <= 1'b0;
      frame_start_p1 <= 1'b0;
      underflow_p1   <= 1'b0;
    end else begin
      rgb_p1         <= !active ? '0 : (take ? pix_data : FILL_RGB);
      hd_p1          <= ~hsync_region;
      vd_p1          <= ~vsync_region;
      vld_p1         <= active;
      frame_start_p1 <= at_origin;
      underflow_p1   <= underflow_p1 | starve;
    end
  end

  assign rgb_out     = rgb_p1;
  assign hd          = hd_p1;
  assign vd          = vd_p1;
  assign den         = vld_p1;
  assign frame_start = frame_start_p1;
  assign underflow   = underflow_p1;

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Raster timing stage between the frame-buffer pixel reader (SDRAM stream) and the LCD pins (RGB, HD, VD, DEN).
- Consumes a 24-bit pixel stream with valid/ready/start-of-frame handshake and generates panel timing for the 800x480 LCD.
- Aligns the first pixel of each stream frame to raster (0,0) and substitutes a fill colour on stream underflow.
- Runs entirely on the LCD pixel clock; the upstream FIFO handles the clock-domain crossing.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, HD low width (clocks)
H_BP, 88, horizontal back porch (clocks); H_TOTAL = sum = 1056
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VD low width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
FILL_RGB, 24'h000000, colour driven on underflow

Ports:
clk  in  1  LCD pixel clock
reset_n  in  1  asynchronous active-low reset
pix_data  in  24  {R[7:0],G[7:0],B[7:0]} from frame-buffer reader
pix_valid  in  1  pix_data/pix_sop valid
pix_sop  in  1  first pixel of a frame
pix_ready  out  1  pixel accepted when pix_valid & pix_ready
rgb_out  out  24  pixel to panel, registered
hd  out  1  horizontal sync, active low, registered
vd  out  1  vertical sync, active low, registered
den  out  1  data enable, registered
frame_start  out  1  one-cycle pulse when counters wrap to (0,0)
underflow  out  1  sticky; set on starvation, cleared only by reset

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1. h wraps to 0 and v increments at h_cnt = H_TOTAL-1; v wraps to 0 at V_TOTAL-1.
- Line order: active, front porch, sync, back porch; frame order is the same.
- active = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- hsync_region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync_region uses the same rule on v_cnt.
- Output latency: hd, vd, den and rgb_out are registered 1 cycle after the counter state they reflect.
- hd = ~hsync_region; vd = ~vsync_region; den = active.
- rgb_out = pix_data when accepted; otherwise FILL_RGB in active cycles; 0 when den = 0.
- frame_start is registered and aligned with the first den of the frame: high the cycle after h_cnt = 0, v_cnt = 0.
- Reset values: h_cnt = 0, v_cnt = 0, state = ALIGN, hd = 1, vd = 1, den = 0, rgb_out = 0, frame_start = 0, underflow = 0. Counters free-run from (0,0) after reset release.
- pix_ready is combinational from state, counters, pix_valid and pix_sop.
- ALIGN state (discards the stream until a frame head is parked):
  - pix_ready = pix_valid & ~pix_sop; non-SOP pixels are dropped.
  - A valid SOP pixel is held (ready = 0) until h_cnt = 0, v_cnt = 0. It is accepted in that cycle and the state moves to RUN.
  - Display shows FILL_RGB with normal sync while in ALIGN.
- RUN state:
  - pix_ready = active & ~(pix_sop & (h_cnt != 0 | v_cnt != 0)).
  - Active cycle with pix_valid = 0: FILL_RGB is driven, underflow is set, and the state goes to ALIGN. The remaining frame is filled.
  - SOP at a position other than (0,0): not consumed, state goes to ALIGN (SOP is then realigned at the next frame). underflow is not set.
  - SOP expected at (0,0) but pix_sop = 0: the pixel is consumed normally; no check.
- Simultaneous events: the underflow check takes precedence over the misaligned-SOP check. A frame wrap at the same cycle as ALIGN->RUN is the defined entry point.
- Reset assertion mid-frame: all outputs return to reset values immediately (asynchronous). No pixel is accepted while reset_n = 0.

Test Plan:
1. Small params (H 4/1/1/2 = 8 total, V 3/1/1/1 = 6 total), stream 12-pixel frames with SOP on the first, always valid. Required response:
   - den high 4 cycles per line on lines 0-2.
   - hd low exactly at h_cnt = 5 (visible one cycle later).
   - vd low for line 4.
   - rgb_out equals the pixel sequence.
   - frame_start every 48 cycles; underflow stays 0.
2. After reset, present 5 non-SOP pixels then an SOP frame. Required response:
   - The 5 pixels are dropped immediately.
   - SOP is held with pix_ready = 0 until (0,0), then the first den cycle shows the SOP pixel.
3. Drop pix_valid for 1 cycle at pixel 6 of frame 2. Required response:
   - rgb_out = FILL_RGB at that slot; underflow = 1 and stays set.
   - The rest of the frame shows FILL; realigns on the next SOP at (0,0).
4. Inject SOP at pixel 3 mid-frame. Required response:
   - Not accepted; the remaining frame shows FILL; underflow = 0.
   - That SOP pixel appears at the next frame's first den cycle.
5. Assert reset_n low mid-line with den = 1. Required response:
   - hd = vd = 1, den = 0, rgb_out = 0 asynchronously.
   - After release, h_cnt restarts at 0 and the first frame_start occurs on the first clock.
6. Default params, one full frame. Required response:
   - 1056 clocks per line, 525 lines per frame.
   - 800 den cycles per line; 128-clock hd low; 2-line vd low.
